// File: rtl/sent_tx_pkg.sv
// SENT transmitter shared types and default pulse constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: frame-sequencer state enum, default timing constants in ticks,
// and the nibble pulse-length helper.
package sent_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        NIB,
        PAUSE
    } tx_state_e;

    localparam int LOW_TICKS_DEF  = 5;
    localparam int SYNC_TICKS_DEF = 56;
    localparam int NIB_BASE_DEF   = 12;

    // Nibble pulse length in ticks: base length plus the nibble value.
    function automatic int nib_len(input logic [3:0] value, input int base);
        return base + int'(value);
    endfunction

endpackage

// File: rtl/sent_tx_pulse_timer.sv
// Single SENT pulse timer: low for LOW_TICKS ticks, then high, length latched at tick 0.
// Latency: tick 0 starts on the first tick_en after arm; last_o fires on the tick_en that begins the final tick.
// Backpressure: none; advances only on tick_en, clr/arm override any running pulse.
//
// Ports:
//   clk, reset_n_tx     system clock, async active-low reset
//   tick_en             one-clk tick strobe
//   arm                 prepare a new pulse (starts on next tick_en)
//   clr                 stop and return the line high
//   len                 pulse length in ticks, sampled on the tick-0 edge
//   start_o             this clk is the tick-0 edge of an armed pulse
//   last_o              this clk begins the pulse's final (high) tick
//   level_o             line level
module sent_tx_pulse_timer #(
    parameter int CNT_W     = 9,
    parameter int LOW_TICKS = 5
)(
    input  logic             clk,
    input  logic             reset_n_tx,
    input  logic             tick_en,
    input  logic             arm,
    input  logic             clr,
    input  logic [CNT_W-1:0] len,
    output logic             start_o,
    output logic             last_o,
    output logic             level_o
);

    logic             armed;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;

    assign start_o = tick_en & armed;
    // The final tick is always high, so the timer drops out of run one tick
    // early; the next pulse (or idle) then owns that tick with the line high.
    assign last_o  = tick_en & run & (cnt == len_q - CNT_W'(2));
    assign level_o = ~(run & (cnt < CNT_W'(LOW_TICKS)));

    always_ff @(posedge clk or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            armed <= 1'b0;
            run   <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else if (clr) begin
            armed <= 1'b0;
            run   <= 1'b0;
        end else if (arm) begin
            armed <= 1'b1;
            run   <= 1'b0;
        end else if (start_o) begin
            armed <= 1'b0;
            run   <= 1'b1;
            cnt   <= '0;
            len_q <= len;
        end else if (tick_en && run) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SENT frame pulse engine: sync, 1..MAX_NIBBLES nibble pulses, optional length-equalising pause.
// Latency: busy one clk after an accepted frame_start_i; first sync low tick on the next tick_en.
// Backpressure: single-entry nibble holding register, nib_ready_o while empty; late nibble -> value 0 + sticky underrun.
//
// Optional feature macro SENT_TX_PAUSE_EN: adds PAUSE state, tick accumulator and FRAME_TICKS parameter.
// Ports:
//   clk, reset_n_tx            system clock, async active-low reset
//   tick_en                    one-clk strobe per SENT tick
//   frame_start_i, nib_cnt_i   frame request and nibble count (sampled in IDLE)
//   nib_data_i/valid_i/ready_o nibble stream from the frame builder
//   busy_o, frame_done_o       frame in progress, one-clk end-of-frame pulse
//   underrun_o                 sticky: a nibble was missing when needed
//   sent_o                     SENT line level, idle high
module sent_tx_frame_gen
    import sent_tx_pkg::*;
#(
    parameter int LOW_TICKS   = LOW_TICKS_DEF,
    parameter int SYNC_TICKS  = SYNC_TICKS_DEF,
    parameter int NIB_BASE    = NIB_BASE_DEF,
    parameter int MAX_NIBBLES = 8,
`ifdef SENT_TX_PAUSE_EN
    parameter int FRAME_TICKS = 300,
`endif
    parameter int CNT_W       = 9
)(
    input  logic                             clk,
    input  logic                             reset_n_tx,
    input  logic                             tick_en,
    input  logic                             frame_start_i,
    input  logic [$clog2(MAX_NIBBLES+1)-1:0] nib_cnt_i,
    input  logic [3:0]                       nib_data_i,
    input  logic                             nib_valid_i,
    output logic                             nib_ready_o,
    output logic                             busy_o,
    output logic                             frame_done_o,
    output logic                             underrun_o,
    output logic                             sent_o
);

    localparam int NC_W = $clog2(MAX_NIBBLES+1);

    tx_state_e        state;
    logic [NC_W-1:0]  nib_cnt_q;
    logic [NC_W-1:0]  fetched;
    logic [NC_W-1:0]  consumed;
    logic             hold_vld;
    logic [3:0]       hold_dat;
    logic             busy_q;
    logic             done_q;
    logic             underrun_q;

    logic             start_ok;
    logic             xfer;
    logic             consume;
    logic             nib_last;
    logic [3:0]       nib_val;

    logic             t_arm;
    logic             t_clr;
    logic             t_start;
    logic             t_last;
    logic             t_level;
    logic [CNT_W-1:0] t_len;

`ifdef SENT_TX_PAUSE_EN
    localparam logic [CNT_W-1:0] ACC_MAX = '1;
    logic [CNT_W-1:0] acc;
    logic [CNT_W:0]   acc_sum;
    logic [CNT_W-1:0] pause_len;

    assign acc_sum = {1'b0, acc} + {1'b0, t_len};
    // Compare before subtracting so an accumulator beyond FRAME_TICKS
    // clamps to the minimum instead of wrapping.
    assign pause_len = ((acc == ACC_MAX) || (acc > CNT_W'(FRAME_TICKS - NIB_BASE)))
                     ? CNT_W'(NIB_BASE) : (CNT_W'(FRAME_TICKS) - acc);
`endif

    assign start_ok = (state == IDLE) && frame_start_i &&
                      (nib_cnt_i != '0) && (nib_cnt_i <= NC_W'(MAX_NIBBLES));
    assign nib_ready_o = busy_q && !hold_vld && (fetched < nib_cnt_q);
    assign xfer        = nib_valid_i && nib_ready_o;
    assign consume     = t_start && (state == NIB);
    assign nib_last    = (consumed == nib_cnt_q);
    assign nib_val     = hold_vld ? hold_dat : 4'd0;

    always_comb begin
        t_arm = 1'b0;
        t_clr = 1'b0;
        t_len = CNT_W'(SYNC_TICKS);
        case (state)
            IDLE: t_arm = start_ok;
            SYNC: t_arm = t_last;
            NIB: begin
                t_len = CNT_W'(nib_len(nib_val, NIB_BASE));
                if (t_last) begin
`ifdef SENT_TX_PAUSE_EN
                    t_arm = 1'b1;
`else
                    t_arm = !nib_last;
                    t_clr = nib_last;
`endif
                end
            end
`ifdef SENT_TX_PAUSE_EN
            PAUSE: begin
                t_len = pause_len;
                t_clr = t_last;
            end
`endif
            default: t_clr = 1'b1;
        endcase
    end

    sent_tx_pulse_timer #(
        .CNT_W     (CNT_W),
        .LOW_TICKS (LOW_TICKS)
    ) u_timer (
        .clk        (clk),
        .reset_n_tx (reset_n_tx),
        .tick_en    (tick_en),
        .arm        (t_arm),
        .clr        (t_clr),
        .len        (t_len),
        .start_o    (t_start),
        .last_o     (t_last),
        .level_o    (t_level)
    );

    always_ff @(posedge clk or negedge reset_n_tx) begin
        if (!reset_n_tx) begin
            state      <= IDLE;
            nib_cnt_q  <= '0;
            fetched    <= '0;
            consumed   <= '0;
            hold_vld   <= 1'b0;
            hold_dat   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef SENT_TX_PAUSE_EN
            acc        <= '0;
`endif
        end else begin
            done_q <= 1'b0;

            // A transfer only happens into an empty register, so an empty
            // consume and a refill on the same clk leave the new nibble held.
            if (xfer) begin
                hold_vld <= 1'b1;
                hold_dat <= nib_data_i;
                fetched  <= fetched + NC_W'(1);
            end else if (consume) begin
                hold_vld <= 1'b0;
            end

            if (consume) begin
                consumed <= consumed + NC_W'(1);
                if (!hold_vld) begin
                    underrun_q <= 1'b1;
                end
            end

`ifdef SENT_TX_PAUSE_EN
            if (t_start && (state == SYNC || state == NIB)) begin
                acc <= acc_sum[CNT_W] ? ACC_MAX : acc_sum[CNT_W-1:0];
            end
`endif

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state      <= SYNC;
                        busy_q     <= 1'b1;
                        nib_cnt_q  <= nib_cnt_i;
                        underrun_q <= 1'b0;
                        fetched    <= '0;
                        consumed   <= '0;
                        hold_vld   <= 1'b0;
`ifdef SENT_TX_PAUSE_EN
                        acc        <= '0;
`endif
                    end
                end
                SYNC: begin
                    if (t_last) begin
                        state <= NIB;
                    end
                end
                NIB: begin
                    if (t_last && nib_last) begin
`ifdef SENT_TX_PAUSE_EN
                        state <= PAUSE;
`else
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`endif
                    end
                end
`ifdef SENT_TX_PAUSE_EN
                PAUSE: begin
                    if (t_last) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign underrun_o   = underrun_q;
    assign sent_o       = t_level;

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Directed bench for sent_tx_frame_gen: expected line waveforms built from pulse-length lists.
// Latency: n/a.
// Backpressure: nibble feeder presents queued nibbles; an empty queue withholds valid.
module tb_sent_tx_frame_gen;

    localparam int TB_FRAME = 250;
    localparam int LOWT     = 5;
    localparam int SYNCT    = 56;
    localparam int NBASE    = 12;

    logic       clk = 1'b0;
    logic       reset_n_tx = 1'b0;
    logic       tick_en = 1'b0;
    logic       frame_start = 1'b0;
    logic [3:0] nib_cnt = 4'd0;
    logic [3:0] nib_data = 4'd0;
    logic       nib_valid = 1'b0;
    logic       nib_ready;
    logic       busy;
    logic       done;
    logic       underrun;
    logic       sent;

    int checks = 0;
    int errors = 0;

    int feed_q[$];
    int plen[32];
    bit pend[32];
    int np;
    int mtot;
    int nv[8];

`ifdef SENT_TX_PAUSE_EN
    sent_tx_frame_gen #(.FRAME_TICKS(TB_FRAME)) dut (
`else
    sent_tx_frame_gen dut (
`endif
        .clk           (clk),
        .reset_n_tx    (reset_n_tx),
        .tick_en       (tick_en),
        .frame_start_i (frame_start),
        .nib_cnt_i     (nib_cnt),
        .nib_data_i    (nib_data),
        .nib_valid_i   (nib_valid),
        .nib_ready_o   (nib_ready),
        .busy_o        (busy),
        .frame_done_o  (done),
        .underrun_o    (underrun),
        .sent_o        (sent)
    );

    initial forever #5 clk = ~clk;

    // One tick every 4 clks, changed on the falling edge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            tick_en = (div == 0);
        end
    end

    // Nibble source: presents the queue head, pops it after a handshake.
    initial begin
        bit xfer;
        forever begin
            @(negedge clk);
            xfer = nib_valid && nib_ready;
            @(posedge clk);
            #1;
            if (xfer) void'(feed_q.pop_front());
            nib_valid = (feed_q.size() != 0);
            nib_data  = (feed_q.size() != 0) ? 4'(feed_q[0]) : 4'd0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (tick_en !== 1'b1);
        #1;
    endtask

    task automatic clear_model();
        np = 0;
        mtot = 0;
    endtask

    task automatic add_pulse(input int len, input bit is_end);
        plen[np] = len;
        pend[np] = is_end;
        np++;
        mtot += len;
    endtask

    // nv[i] < 0 marks a nibble that will be missing (sent as value 0).
    task automatic add_frame(input int n);
        int acc;
        acc = SYNCT;
        add_pulse(SYNCT, 1'b0);
        for (int i = 0; i < n; i++) begin
            int l;
            l = NBASE + ((nv[i] < 0) ? 0 : nv[i]);
            acc += l;
`ifdef SENT_TX_PAUSE_EN
            add_pulse(l, 1'b0);
`else
            add_pulse(l, i == n - 1);
`endif
        end
`ifdef SENT_TX_PAUSE_EN
        add_pulse((acc + NBASE > TB_FRAME) ? NBASE : TB_FRAME - acc, 1'b1);
`endif
    endtask

    // Requests a frame and compares every tick against the model waveform.
    task automatic run_frame(input string tag, input logic [3:0] n, input int hold_edges);
        bit exp_lvl[700];
        bit exp_done[700];
        int e;
        int total;
        int lvl_bad;
        int done_bad;
        for (int k = 0; k < 700; k++) begin
            exp_lvl[k]  = 1'b1;
            exp_done[k] = 1'b0;
        end
        e = 1;
        for (int p = 0; p < np; p++) begin
            for (int t = 0; t < plen[p]; t++) exp_lvl[e + t] = (t >= LOWT);
            if (pend[p]) exp_done[e + plen[p] - 1] = 1'b1;
            e += plen[p];
        end
        total = e - 1;
        nib_cnt = n;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " busy_start"}, busy, 1);
        chk({tag, " underrun_clr"}, underrun, 0);
        if (hold_edges == 0) frame_start = 1'b0;
        lvl_bad = 0;
        done_bad = 0;
        for (int k = 1; k <= total + 3; k++) begin
            wait_tick();
            if (sent !== exp_lvl[k]) lvl_bad++;
            if (done !== exp_done[k]) done_bad++;
            if (k == hold_edges) frame_start = 1'b0;
        end
        chk({tag, " line_bad_ticks"}, lvl_bad, 0);
        chk({tag, " done_bad_ticks"}, done_bad, 0);
        chk({tag, " busy_end"}, busy, 0);
    endtask

    initial begin
        int bad;
        int h;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst sent", sent, 1);
        chk("rst busy", busy, 0);
        chk("rst ready", nib_ready, 0);
        chk("rst done", done, 0);
        chk("rst underrun", underrun, 0);
        reset_n_tx = 1'b1;

        // 100 idle ticks, including requests with illegal nibble counts
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            frame_start = (k >= 20 && k < 40) || (k >= 60 && k < 80);
            nib_cnt = (k < 50) ? 4'd0 : 4'd9;
            wait_tick();
            if (sent !== 1'b1 || busy !== 1'b0 || nib_ready !== 1'b0 || done !== 1'b0) bad++;
        end
        frame_start = 1'b0;
        chk("idle bad_ticks", bad, 0);

        // One nibble of value 0: 56 + 12 ticks
        clear_model();
        nv[0] = 0;
        add_frame(1);
        feed_q.push_back(0);
        run_frame("one_nib0", 4'd1, 0);
        chk("one_nib0 ready_end", nib_ready, 0);

        // Second nibble withheld: sent as 12 ticks, underrun sticks
        clear_model();
        nv[0] = 3;
        nv[1] = -1;
        add_frame(2);
        feed_q.push_back(3);
        run_frame("underrun", 4'd2, 0);
        chk("underrun sticky", underrun, 1);
        repeat (5) wait_tick();
        chk("underrun still", underrun, 1);

        // Value 15 gives 27 ticks; new frame clears underrun
        clear_model();
        nv[0] = 15;
        add_frame(1);
        feed_q.push_back(15);
        run_frame("nib15", 4'd1, 0);
        chk("nib15 underrun", underrun, 0);

        // Back-to-back with frame_start held through the first frame
        clear_model();
        nv[0] = 5;
        add_frame(1);
        h = mtot + 2;
        nv[0] = 9;
        add_frame(1);
        feed_q.push_back(5);
        feed_q.push_back(9);
        run_frame("b2b", 4'd1, h);

        // Eight nibbles 0..7
        clear_model();
        for (int i = 0; i < 8; i++) begin
            nv[i] = i;
            feed_q.push_back(i);
        end
        add_frame(8);
        run_frame("eight_ramp", 4'd8, 0);

        // Eight nibbles of 15 (pause clamps to the minimum when enabled)
        clear_model();
        for (int i = 0; i < 8; i++) begin
            nv[i] = 15;
            feed_q.push_back(15);
        end
        add_frame(8);
        run_frame("eight_max", 4'd8, 0);
        chk("eight_max underrun", underrun, 0);

        // Reset in the middle of the first nibble pulse
        feed_q.push_back(4);
        nib_cnt = 4'd1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        repeat (SYNCT + 2) wait_tick();
        chk("midrst low_before", sent, 0);
        chk("midrst busy_before", busy, 1);
        #2;
        reset_n_tx = 1'b0;
        #1;
        chk("midrst sent", sent, 1);
        chk("midrst busy", busy, 0);
        @(posedge clk);
        #1;
        reset_n_tx = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            wait_tick();
            if (sent !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("post_rst idle", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sent_tx_frame_gen.md
Name: sent_tx_frame_gen

Overview:
Parametrised SENT transmitter pulse engine that sequences a complete frame autonomously: sync pulse, 1..MAX_NIBBLES nibble pulses, and an optional frame-length-equalising pause pulse. Nibbles arrive over a valid/ready stream from the frame builder (status/data/CRC assembled upstream). Sits between the frame builder and the TX pad driver. Runs on the system clock, gated by a tick strobe instead of clocking on ticks.

Parameters:
LOW_TICKS, 5, low-phase length of every pulse in ticks
SYNC_TICKS, 56, total sync pulse length in ticks
NIB_BASE, 12, nibble pulse length for value 0 (length = NIB_BASE + value)
MAX_NIBBLES, 8, maximum nibble pulses per frame
FRAME_TICKS, 300, fixed frame length in ticks when pause is enabled
CNT_W, 9, tick counter width; must hold FRAME_TICKS

Ports:
clk  in  1  system clock
reset_n_tx  in  1  asynchronous, active-low reset
tick_en  in  1  one-clk strobe per SENT tick
frame_start_i  in  1  request a frame; sampled only in IDLE
nib_cnt_i  in  $clog2(MAX_NIBBLES+1)  nibble pulses in frame, latched with frame_start_i
nib_data_i  in  4  nibble value
nib_valid_i  in  1  nib_data_i valid
nib_ready_o  out  1  holding register can accept a nibble
busy_o  out  1  frame in progress
frame_done_o  out  1  one-clk pulse at end of frame
underrun_o  out  1  sticky: nibble not available when required
sent_o  out  1  SENT line level (idle high)

Behaviour:
- Reset: sent_o=1, busy_o=0, nib_ready_o=0, frame_done_o=0, underrun_o=0, state IDLE, all counters 0, holding register empty. Asserting reset mid-frame aborts immediately; line returns high asynchronously.
- States: IDLE, SYNC, NIB, PAUSE. All state and counter advances occur only on clk edges with tick_en=1; handshake logic runs on every clk.
- IDLE: sent_o=1. frame_start_i=1 with nib_cnt_i in 1..MAX_NIBBLES latches count, clears underrun_o and tick accumulator, sets busy_o next clk, enters SYNC. nib_cnt_i=0 or >MAX_NIBBLES: request ignored. frame_start_i while busy_o=1: ignored.
- Pulse shape (all states except IDLE): ticks 0..LOW_TICKS-1 of a pulse drive sent_o=0, remaining ticks drive 1; pulse length L ticks. First low tick on the first tick_en after entering the state.
- SYNC: L=SYNC_TICKS, then NIB.
- NIB: at pulse tick 0 the holding register is consumed; L=NIB_BASE+value. If empty, value 0 is used and underrun_o set. After the nib_cnt-th nibble go to PAUSE (or IDLE, see feature).
- Handshake: single-entry holding register. nib_ready_o=1 while busy_o=1, register empty, and nibbles fetched < nib_cnt. Transfer on clk with nib_valid_i & nib_ready_o. Prefetch during SYNC is expected; consume and refill on the same clk are allowed.
- Tick accumulator: counts all ticks of sync and nibble pulses, width CNT_W, saturating.
- PAUSE: L = FRAME_TICKS - accumulator; if result < NIB_BASE or accumulator saturated, L = NIB_BASE.
- End of frame: frame_done_o=1 for one clk on the tick ending the last pulse; busy_o=0 on the same edge; state IDLE. frame_start_i on that same clk is accepted (back-to-back frames, no extra idle tick).
- Arithmetic is unsigned, widths CNT_W; value 15 nibble gives 27 ticks.

Optional Feature:
SENT_TX_PAUSE_EN: defined -> PAUSE state present, every frame exactly FRAME_TICKS (subject to NIB_BASE minimum). Undefined -> PAUSE state and accumulator removed; frame ends after the last nibble pulse, and frame length is variable.

Decomposition:
- Package sent_tx_pkg: state enum (IDLE/SYNC/NIB/PAUSE), default constants LOW_TICKS, SYNC_TICKS, NIB_BASE, and the nibble-length helper function.
- Sub-module sent_tx_pulse_timer: given length L and tick_en, produces the low/high level and a last-tick flag; instantiated once.

Test Plan:
- Reset then idle: no frame_start_i for 100 ticks -> sent_o stays 1, busy_o=0, nib_ready_o=0.
- nib_cnt_i=1, nibble 0, PAUSE_EN off -> 5 low/51 high, 5 low/7 high, frame_done_o after 68 ticks.
- nib_cnt_i=8, nibbles 0..7, PAUSE_EN on -> nibble lengths 12..19, accumulator 180, pause 120 ticks, frame 300 ticks total.
- nib_cnt_i=8, all 15, FRAME_TICKS=250 -> accumulator 272 > 250, pause clamped to 12 ticks.
- Withhold nib_valid_i for 2nd nibble -> nibble sent as 12 ticks, underrun_o=1 until next frame_start_i.
- Back-to-back: frame_start_i held high -> second sync low tick follows the first frame's last tick directly; reset asserted mid-NIB -> sent_o=1 immediately, busy_o=0.
